regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the register file's single write port (enc/addrc/datac) among NREQ
//   writeback sources: ALU, load unit and mult/div unit.
//   Round-robin arbitration with a valid/ready handshake per requester.
//   Registered output drives the register file write port one cycle after acceptance.
//   Writes to $zero are accepted and then suppressed.
//   Counts contention cycles for performance debug.
// PARAMETERS
//   NREQ  3   number of requesters (2..4)
//   AW    5   register address width
//   DW    32  register data width
//   IDW   2   width of grant id; 2**IDW >= NREQ
//   CW    16  width of contention counter
// PORTS
//   clock         in   1         system clock, all logic on rising edge
//   reset         in   1         synchronous, active-high reset
//   hold          in   1         1 = no grants this cycle (port frozen)
//   req_valid     in   NREQ      per-requester write request
//   req_addr      in   NREQ*AW   requester i address at [i*AW +: AW]
//   req_data      in   NREQ*DW   requester i data at [i*DW +: DW]
//   req_ready     out  NREQ      one-hot grant; transfer when valid&ready
//   enc           out  1         register file write enable (registered)
//   addrc         out  AW        register file write address (registered)
//   datac         out  DW        register file write data (registered)
//   grant_id      out  IDW       index of requester whose write is on port
//   contention    out  CW        saturating count of cycles with >=2 valid
// BEHAVIOUR
//   Reset
//   - reset=1 at a clock edge sets enc=0, addrc=0, datac=0, grant_id=0,
//     contention=0 and ptr=0.
//   - req_ready is forced to 0 while reset=1.
//   - Reset mid-operation drops any accepted but not yet issued write: enc=0 next cycle.
//   Arbitration (combinational, same cycle)
//   - Search i = ptr, ptr+1, ... mod NREQ; the first i with req_valid[i]=1 wins.
//   - req_ready[i]=1 only for the winner. At most one bit of req_ready is set.
//   - hold=1 or no valid requester: req_ready=0.
//   - req_ready may depend on req_valid. Requesters must not make req_valid
//     depend on req_ready.
//   - A requester holds valid/addr/data stable until it sees ready.
//   Pointer update (at clock edge)
//   - Grant to i: ptr <= (i+1) mod NREQ.
//   - No grant: ptr unchanged.
//   - With all requesters valid, grants rotate 0,1,2,0,...
//   Write port (latency 1)
//   - Cycle after a grant to i with addr!=0: enc=1, addrc=addr, datac=data, grant_id=i.
//   - Cycle after a grant with addr==0: enc=0; addrc, datac and grant_id hold.
//     The handshake still completes.
//   - Cycle after no grant: enc=0; addrc, datac and grant_id hold previous values.
//   - Back-to-back grants give enc=1 on consecutive cycles. No bubble is required.
//   Contention counter
//   - Increments when reset=0 and popcount(req_valid)>=2, regardless of hold.
//   - Saturates at 2**CW-1; does not wrap.
//   Boundaries
//   - ptr never exceeds NREQ-1.
//   - Valid bits for indices >= NREQ do not exist.
//   - A requester that drops valid before being granted loses nothing; the pointer is unaffected.
// TESTING
//   1 Reset: reset=1 for 2 cycles with all valid=1
//     -> req_ready=0, enc=0, addrc=0, datac=0, contention=0.
//   2 Single: req 1 valid, addr=7, data=32'h233
//     -> ready=3'b010 same cycle; next cycle enc=1, addrc=7, datac=32'h233, grant_id=1.
//   3 Round-robin: all 3 valid for 6 cycles with ptr=0
//     -> grant_id sequence 0,1,2,0,1,2; enc=1 every cycle; contention=6.
//   4 $zero: req 0 valid, addr=0, data=32'hFFFF
//     -> ready[0]=1; next cycle enc=0, addrc/datac unchanged.
//   5 Hold: all valid and hold=1 for 3 cycles
//     -> ready=0, enc=0, ptr unchanged; first grant after release goes to the old ptr.
//   6 Saturation (CW=4): 20 contention cycles -> contention=15 and stays 15.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback sources and the register file arbiter.
// Requester side drives hold/valid/addr/data; the arbiter drives ready, the write port, counters and ptr.
interface regfile_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2,
  parameter int CW   = 16
);
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 enc;
  logic [AW-1:0]        addrc;
  logic [DW-1:0]        datac;
  logic [IDW-1:0]       grant_id;
  logic [CW-1:0]        contention;
  logic [IDW-1:0]       dbg_ptr;

  // Handshake: requester i transfers when req_valid[i] & req_ready[i] at a rising edge.
  // req_ready may depend on req_valid in the same cycle, never the reverse, and a
  // requester keeps valid/addr/data stable until it sees ready.
  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, enc, addrc, datac, grant_id, contention, dbg_ptr
  );
  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, enc, addrc, datac, grant_id, contention, dbg_ptr
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// writeback sources; registered write port, $zero writes dropped, contention counter.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int IDW  = 2,
  parameter int CW   = 16
) (
  input logic                   clock,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  logic [IDW-1:0]  r_ptr;
  logic            r_enc;
  logic [AW-1:0]   r_addrc;
  logic [DW-1:0]   r_datac;
  logic [IDW-1:0]  r_grant_id;
  logic [CW-1:0]   r_contention;

  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_cand;
  logic [NREQ-1:0] w_ready;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [IDW:0]    w_nvalid;
  logic            w_contend;
  logic [IDW-1:0]  w_ptr_next;

  // Search starts at the pointer and wraps; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_ready = '0;
    if (!reset && !bus.hold) begin
      for (int k = 0; k < NREQ; k++) begin
        w_cand = IDW'((int'(r_ptr) + k) % NREQ);
        if (!w_found && bus.req_valid[w_cand]) begin
          w_found = 1'b1;
          w_win   = w_cand;
        end
      end
    end
    if (w_found) w_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_nvalid = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_nvalid = w_nvalid + (IDW+1)'(bus.req_valid[k]);
    end
    w_contend = !reset && (w_nvalid >= (IDW+1)'(2));
  end

  assign w_addr     = bus.req_addr[int'(w_win)*AW +: AW];
  assign w_data     = bus.req_data[int'(w_win)*DW +: DW];
  assign w_ptr_next = (int'(w_win) == NREQ-1) ? '0 : w_win + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr        <= '0;
      r_enc        <= 1'b0;
      r_addrc      <= '0;
      r_datac      <= '0;
      r_grant_id   <= '0;
      r_contention <= '0;
    end else begin
      // A granted write to $zero completes its handshake but never reaches the port.
      r_enc <= w_found && (w_addr != '0);
      if (w_found && (w_addr != '0)) begin
        r_addrc    <= w_addr;
        r_datac    <= w_data;
        r_grant_id <= w_win;
      end
      if (w_found) r_ptr <= w_ptr_next;
      if (w_contend && (r_contention != '1)) r_contention <= r_contention + 1'b1;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.enc        = r_enc;
  assign bus.addrc      = r_addrc;
  assign bus.datac      = r_datac;
  assign bus.grant_id   = r_grant_id;
  assign bus.contention = r_contention;
  assign bus.dbg_ptr    = r_ptr;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus constrained-random traffic,
// scoreboard of expected write-port states, second instance with a 4-bit counter.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int IDW  = 2;
  localparam int EW   = 1 + AW + DW + IDW;

  logic clock = 1'b0;
  logic reset = 1'b1;

  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .CW(16)) bus16 ();
  regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .CW(4))  bus4 ();

  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .CW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus16.slave)
  );
  regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW), .CW(4)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.hold      = bus16.hold;
  assign bus4.req_valid = bus16.req_valid;
  assign bus4.req_addr  = bus16.req_addr;
  assign bus4.req_data  = bus16.req_data;

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  int m_ptr = 0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_data = '0;
  int m_id = 0;
  int m_cont16 = 0;
  int m_cont4 = 0;
  logic [NREQ-1:0] m_ready = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic hld, input logic [NREQ-1:0] v,
                      input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
    int win;
    int idx;
    logic e_enc;
    logic [AW-1:0] wa;
    logic [EW-1:0] e;
    @(negedge clock);
    reset = rst;
    bus16.hold = hld;
    bus16.req_valid = v;
    bus16.req_addr = a;
    bus16.req_data = d;
    #1;
    win = -1;
    m_ready = '0;
    if (!rst && !hld) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && v[idx]) win = idx;
      end
    end
    if (win >= 0) m_ready[win] = 1'b1;
    check_val("req_ready", 64'(bus16.req_ready), 64'(m_ready));
    e_enc = 1'b0;
    if (rst) begin
      m_ptr = 0; m_addr = '0; m_data = '0; m_id = 0; m_cont16 = 0; m_cont4 = 0;
    end else begin
      if (win >= 0) begin
        wa = a[win*AW +: AW];
        if (wa != '0) begin
          e_enc = 1'b1;
          m_addr = wa;
          m_data = d[win*DW +: DW];
          m_id = win;
        end
        m_ptr = (win + 1) % NREQ;
      end
      if ($countones(v) >= 2) begin
        if (m_cont16 < 65535) m_cont16++;
        if (m_cont4 < 15) m_cont4++;
      end
    end
    exp_q.push_back({e_enc, m_addr, m_data, IDW'(m_id)});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check_val("enc",      64'(bus16.enc),      64'(e[EW-1]));
    check_val("addrc",    64'(bus16.addrc),    64'(e[EW-2 -: AW]));
    check_val("datac",    64'(bus16.datac),    64'(e[IDW +: DW]));
    check_val("grant_id", 64'(bus16.grant_id), 64'(e[IDW-1:0]));
    check_val("contention",   64'(bus16.contention), 64'(m_cont16));
    check_val("contention_4", 64'(bus4.contention),  64'(m_cont4));
    check_val("ptr",      64'(bus16.dbg_ptr),  64'(m_ptr));
  endtask

  initial begin
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0] v;
    logic hld;
    bus16.hold = 1'b0;
    bus16.req_valid = '0;
    bus16.req_addr = '0;
    bus16.req_data = '0;
    a = {5'd3, 5'd2, 5'd1};
    d = {32'hC, 32'hB, 32'hA};

    // Reset with everybody requesting.
    step(1'b1, 1'b0, 3'b111, a, d);
    step(1'b1, 1'b0, 3'b111, a, d);
    check_val("reset_enc", 64'(bus16.enc), 64'd0);
    check_val("reset_contention", 64'(bus16.contention), 64'd0);

    // Single requester 1.
    a = {5'd0, 5'd7, 5'd0};
    d = {32'h0, 32'h233, 32'h0};
    step(1'b0, 1'b0, 3'b010, a, d);
    check_val("single_addrc", 64'(bus16.addrc), 64'd7);
    check_val("single_datac", 64'(bus16.datac), 64'h233);
    check_val("single_id", 64'(bus16.grant_id), 64'd1);

    // Bring ptr back to 0, then six cycles of full contention.
    a = {5'd9, 5'd8, 5'd4};
    d = {32'h300, 32'h200, 32'h100};
    step(1'b0, 1'b0, 3'b100, a, d);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'b111, a, d);
    check_val("rr_contention", 64'(bus16.contention), 64'd6);

    // $zero write from requester 0.
    a = {5'd9, 5'd8, 5'd0};
    d = {32'h300, 32'h200, 32'hFFFF};
    step(1'b0, 1'b0, 3'b001, a, d);
    check_val("zero_enc", 64'(bus16.enc), 64'd0);

    // Hold with all valid, then release.
    a = {5'd9, 5'd8, 5'd4};
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'b111, a, d);
    step(1'b0, 1'b0, 3'b111, a, d);

    // Push the 4-bit counter well past saturation.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 3'b111, a, d);
    check_val("sat_contention_4", 64'(bus4.contention), 64'd15);
    step(1'b0, 1'b1, 3'b011, a, d);
    check_val("sat_hold_4", 64'(bus4.contention), 64'd15);

    // Random traffic; pending requests stay stable until granted.
    v = '0;
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!v[r] || m_ready[r]) begin
          v[r] = 1'($urandom_range(0, 1));
          a[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, 31));
          d[r*DW +: DW] = $urandom;
        end
      end
      hld = ($urandom_range(0, 5) == 0);
      step(1'b0, hld, v, a, d);
    end

    // Reset right after a grant drops the pending write.
    step(1'b0, 1'b0, 3'b111, a | {NREQ{5'd1}}, d);
    step(1'b1, 1'b0, 3'b111, a, d);
    check_val("midreset_enc", 64'(bus16.enc), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
